// File: rtl/hps2ip_fetch.sv
// Host-to-IP descriptor ring fetcher. Each ring entry is read as one 32-byte
// AXI INCR burst, streamed out on ent_*, and then the consumer index advances.
module hps2ip_fetch #(
  parameter int C_ERR_HALT = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        dma_en,
  input  logic [31:5] hps2ip_base,
  input  logic [16:0] hps2ip_mindex,
  input  logic [15:0] hps2ip_pi,
  output logic [15:0] hps2ip_ci,
  input  logic [3:0]  c_arcache,
  input  logic [2:0]  c_arprot,
  input  logic [4:0]  c_aruser,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic [4:0]  aruser,
  output logic        arvalid,
  input  logic        arready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [63:0] ent_data,
  output logic        ent_valid,
  output logic        ent_last,
  input  logic        ent_ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] ci;
  logic [16:0] ci_inc;
  logic [15:0] ci_next;
  logic [31:0] addr_next;
  logic        halted;
  logic        start;
  logic        beat;
  logic        last_beat;

  assign halted    = err && (C_ERR_HALT != 0);
  assign start     = dma_en && (hps2ip_mindex != '0) && (hps2ip_pi != ci) && !halted;
  assign beat      = rvalid && rready;
  assign last_beat = beat && rlast;

  // Wrap test is done in 17 bits so a 65536-entry ring wraps correctly.
  assign ci_inc    = {1'b0, ci} + 17'd1;
  assign ci_next   = (ci_inc == hps2ip_mindex) ? '0 : ci_inc[15:0];
  assign addr_next = {hps2ip_base, 5'd0} + {11'd0, ci, 5'd0};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    arvalid    = 1'b0;
    rready     = 1'b0;
    ent_valid  = 1'b0;
    ent_last   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ADDR;
      end
      ADDR: begin
        arvalid = 1'b1;
        if (arready) state_next = DATA;
      end
      DATA: begin
        rready    = ent_ready;
        ent_valid = rvalid;
        ent_last  = rlast;
        if (last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ci     <= '0;
      err    <= 1'b0;
      araddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!dma_en) begin
            ci  <= '0;
            err <= 1'b0;
          end else if (start) begin
            araddr <= addr_next;
          end
        end
        DATA: begin
          if (beat && (rresp != 2'b00)) err <= 1'b1;
          if (last_beat) ci <= ci_next;
        end
        default: ;
      endcase
    end
  end

  assign hps2ip_ci = ci;
  assign arlen     = 4'd3;
  assign arsize    = 3'd3;
  assign arburst   = 2'b01;
  assign arcache   = c_arcache;
  assign arprot    = c_arprot;
  assign aruser    = c_aruser;
  assign ent_data  = rdata;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_hps2ip_fetch.sv
// Directed bench for hps2ip_fetch: a table of ring fetches plus hand-written
// error-halt, late-disable and mid-burst reset sequences.
module tb_hps2ip_fetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        dma_en;
  logic [31:5] hps2ip_base;
  logic [16:0] hps2ip_mindex;
  logic [15:0] hps2ip_pi;
  logic [15:0] hps2ip_ci;
  logic [3:0]  c_arcache;
  logic [2:0]  c_arprot;
  logic [4:0]  c_aruser;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [4:0]  aruser;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [63:0] ent_data;
  logic        ent_valid;
  logic        ent_last;
  logic        ent_ready;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  hps2ip_fetch #(.C_ERR_HALT(1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .dma_en(dma_en),
    .hps2ip_base(hps2ip_base), .hps2ip_mindex(hps2ip_mindex),
    .hps2ip_pi(hps2ip_pi), .hps2ip_ci(hps2ip_ci),
    .c_arcache(c_arcache), .c_arprot(c_arprot), .c_aruser(c_aruser),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arcache(arcache), .arprot(arprot), .aruser(aruser),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .ent_data(ent_data), .ent_valid(ent_valid), .ent_last(ent_last),
    .ent_ready(ent_ready), .busy(busy), .err(err)
  );

  typedef struct {
    logic [15:0] pi;
    logic [31:0] addr;
    bit          toggle;
    logic [15:0] ci_after;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_ar(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (arvalid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("ar_seen", 64'(seen), 64'd1);
  endtask

  task automatic no_ar(input string name, input int cycles);
    bit any;
    any = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (arvalid || busy) any = 1'b1;
    end
    chk(name, 64'(any), 64'd0);
  endtask

  // Serves one burst as an AXI slave; bad_beat<0 means all responses OKAY.
  task automatic run_burst(input logic [31:0] addr, input int bad_beat, input bit toggle,
                           input int ar_delay, input bit drop_en, input logic [15:0] ci_before);
    bit          seen;
    int          n;
    int          cyc;
    logic [63:0] d;
    wait_ar(seen);
    if (!seen) return;
    chk("araddr", 64'(araddr), 64'(addr));
    chk("ar_fixed", {arlen, arsize, arburst}, {4'd3, 3'd3, 2'b01});
    chk("ar_attr", {arcache, arprot, aruser}, {4'h3, 3'h5, 5'h1a});
    if (drop_en) dma_en = 1'b0;
    for (int i = 0; i < ar_delay; i++) begin
      step();
      chk("ar_hold", {arvalid, araddr}, {1'b1, addr});
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("ar_done", {arvalid, busy}, {1'b0, 1'b1});
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      d = {addr, 32'(n)} ^ 64'h5a5a_0f0f_c3c3_9669;
      rvalid = 1'b1;
      rdata = d;
      rlast = (n == 3);
      rresp = (n == bad_beat) ? 2'b10 : 2'b00;
      ent_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk("ent_beat", {ent_valid, ent_last, ent_data}, {1'b1, (n == 3), d});
      chk("rready_mirror", 64'(rready), 64'(ent_ready));
      chk("ci_hold", 64'(hps2ip_ci), 64'(ci_before));
      @(posedge sys_clk);
      if (ent_ready) n++;
      #1;
      cyc++;
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    rresp = 2'b00;
    ent_ready = 1'b1;
    chk("beat_count", 64'(n), 64'd4);
  endtask

  initial begin
    vec_t tbl[9];
    bit   seen;
    tbl[0] = '{16'd1, 32'h1000_0000, 1'b0, 16'd1};
    tbl[1] = '{16'd2, 32'h1000_0020, 1'b1, 16'd2};
    tbl[2] = '{16'd3, 32'h1000_0040, 1'b0, 16'd3};
    tbl[3] = '{16'd4, 32'h1000_0060, 1'b1, 16'd4};
    tbl[4] = '{16'd5, 32'h1000_0080, 1'b0, 16'd5};
    tbl[5] = '{16'd6, 32'h1000_00a0, 1'b0, 16'd6};
    tbl[6] = '{16'd7, 32'h1000_00c0, 1'b0, 16'd7};
    tbl[7] = '{16'd0, 32'h1000_00e0, 1'b0, 16'd0};
    tbl[8] = '{16'd1, 32'h1000_0000, 1'b1, 16'd1};

    sys_rst = 1'b1;
    dma_en = 1'b0;
    hps2ip_base = 27'(32'h1000_0000 >> 5);
    hps2ip_mindex = 17'd0;
    hps2ip_pi = 16'd0;
    c_arcache = 4'h3;
    c_arprot = 3'h5;
    c_aruser = 5'h1a;
    arready = 1'b0;
    rdata = '0;
    rresp = 2'b00;
    rlast = 1'b0;
    rvalid = 1'b0;
    ent_ready = 1'b1;
    repeat (3) step();
    chk("reset_state", {busy, err, arvalid, rready, ent_valid, hps2ip_ci},
        {5'b0, 16'd0});
    chk("reset_araddr", 64'(araddr), 64'd0);
    sys_rst = 1'b0;

    // Ring disabled by mindex=0 even with work pending.
    dma_en = 1'b1;
    hps2ip_pi = 16'd1;
    no_ar("mindex0_no_ar", 6);
    hps2ip_mindex = 17'd8;

    for (int i = 0; i < 9; i++) begin
      hps2ip_pi = tbl[i].pi;
      run_burst(tbl[i].addr, -1, tbl[i].toggle, 0, 1'b0, (i == 0) ? 16'd0 : tbl[i-1].ci_after);
      chk("ci_after", 64'(hps2ip_ci), 64'(tbl[i].ci_after));
      chk("idle_after", {busy, err}, 2'b00);
      if (i == 7) no_ar("wrap_empty_no_ar", 8);
    end

    // Error on beat 2 halts further fetches until dma_en drops.
    hps2ip_pi = 16'd4;
    run_burst(32'h1000_0020, 1, 1'b0, 0, 1'b0, 16'd1);
    chk("err_set", {err, hps2ip_ci}, {1'b1, 16'd2});
    no_ar("err_halt_no_ar", 10);
    dma_en = 1'b0;
    step();
    chk("disable_clears", {err, hps2ip_ci}, {1'b0, 16'd0});

    // Disable during ADDR with a slow arready: burst still completes.
    hps2ip_pi = 16'd3;
    dma_en = 1'b1;
    run_burst(32'h1000_0000, -1, 1'b0, 5, 1'b1, 16'd0);
    chk("late_disable_ci", {busy, hps2ip_ci}, {1'b0, 16'd1});
    step();
    chk("late_disable_idle", 64'(hps2ip_ci), 64'd0);

    // Reset arriving while beat 2 is presented.
    dma_en = 1'b1;
    run_burst(32'h1000_0000, -1, 1'b0, 0, 1'b0, 16'd0);
    chk("pre_rst_ci", 64'(hps2ip_ci), 64'd1);
    wait_ar(seen);
    chk("rst_araddr", 64'(araddr), 64'h1000_0020);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1;
    rdata = 64'h1111;
    rresp = 2'b10;
    step();
    chk("rst_pre_err", {err, busy}, 2'b11);
    rdata = 64'h2222;
    rresp = 2'b00;
    sys_rst = 1'b1;
    dma_en = 1'b0;
    step();
    rvalid = 1'b0;
    chk("rst_mid_burst", {busy, rready, err, arvalid, ent_valid, hps2ip_ci},
        {5'b0, 16'd0});
    sys_rst = 1'b0;
    step();
    chk("rst_stay_idle", {busy, hps2ip_ci}, {1'b0, 16'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/hps2ip_fetch.md
HPS2IP_FETCH -- requirements
Module: hps2ip_fetch

Interface
REQ-001 Parameter C_ERR_HALT, default 1: 1 = stop issuing reads after any error response until dma_en drops; 0 = record error and continue.
REQ-002 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-003 sys_rst  in  1  synchronous, active-high reset.
REQ-004 dma_en  in  1  fetch enable from register block.
REQ-005 hps2ip_base  in  [31:5]  ring base address, 32-byte aligned.
REQ-006 hps2ip_mindex  in  [16:0]  ring entry count; 0 = ring disabled.
REQ-007 hps2ip_pi  in  [15:0]  producer index written by host.
REQ-008 hps2ip_ci  out  [15:0]  consumer index, read back by register block.
REQ-009 c_arcache / c_arprot / c_aruser  in  4/3/5  AR attributes, driven unchanged onto the AR channel.
REQ-010 araddr  out  32; arlen  out  4; arsize  out  3; arburst  out  2; arcache/arprot/aruser  out  4/3/5; arvalid  out  1; arready  in  1.
REQ-011 rdata  in  64; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1.
REQ-012 ent_data  out  64; ent_valid  out  1; ent_last  out  1; ent_ready  in  1: entry stream to the consumer.
REQ-013 busy  out  1 (state != IDLE); err  out  1 (sticky error flag).

Function
REQ-014 One ring entry is 32 bytes, fetched as one AXI INCR burst: arlen=3, arsize=3, arburst=2'b01, 4 beats.
REQ-015 araddr = {hps2ip_base,5'b0} + {ci,5'b0}, 32-bit arithmetic, carry out discarded.
REQ-016 FSM states: IDLE, ADDR, DATA. At most one burst outstanding.
REQ-017 IDLE->ADDR when dma_en=1, mindex!=0, pi!=ci, and not (err=1 and C_ERR_HALT=1); araddr is registered on this transition.
REQ-018 ADDR: arvalid=1; araddr and attributes held stable until arready; ADDR->DATA on the cycle arvalid&arready.
REQ-019 DATA: ent_valid=rvalid, ent_data=rdata, ent_last=rlast, rready=ent_ready (combinational pass-through). Outside DATA: rready=0, ent_valid=0.
REQ-020 On the rvalid&rready&rlast beat: DATA->IDLE; ci <= (ci+1 == mindex) ? 0 : ci+1, compared in 17 bits.
REQ-021 Any accepted beat with rresp!=2'b00 sets err; the burst still completes and ci still advances.
REQ-022 Deassertion of dma_en in ADDR or DATA does not abort: the current burst completes and ci advances, then the FSM returns to IDLE.
REQ-023 In IDLE with dma_en=0: ci <= 0 and err <= 0.
REQ-024 pi changes during a burst take effect only at the next IDLE evaluation; pi beyond mindex is not checked. Fetching continues until ci==pi.
REQ-025 A wrap from ci=mindex-1 to 0 with pi=0 leaves the ring empty, so no further fetch is issued.

Reset
REQ-026 On sys_rst: state=IDLE, ci=0, err=0, arvalid=0, araddr=0; rready=0, ent_valid=0 and busy=0 follow combinationally from IDLE.
REQ-027 sys_rst asserted mid-burst drops arvalid/rready on the next edge. Outstanding R beats are then ignored; the system resets the interconnect together with this block.

Verification
REQ-028 base=0x1000_0000>>5, mindex=8, pi 0->1, dma_en=1 -> one AR, araddr=0x1000_0000, arlen=3; 4 beats out on ent_*; ci=1; busy=0.
REQ-029 ci=7, mindex=8, pi=0 -> araddr=base+0xE0; ci wraps to 0; no further AR.
REQ-030 ent_ready toggled 1/0 each cycle during DATA -> rready mirrors it; beat order and data intact; ci increments only after the 4th accepted beat.
REQ-031 rresp=2'b10 on beat 2, C_ERR_HALT=1, pi=ci+3 -> err=1, ci advances by 1, no further AR until dma_en pulses low, which clears err and ci.
REQ-032 dma_en dropped during ADDR with arready delayed 5 cycles -> burst completes, ci advances by 1, then ci=0 in IDLE.
REQ-033 sys_rst during DATA beat 2 -> next cycle: state IDLE, ci=0, rready=0, err=0.
